// File: rtl/input_debounce_filter.sv
// Synchroniser plus debounce filter for an asynchronous raw level. Optional macro
// DEBOUNCE_EDGE_PULSE_EN adds the one-cycle rise_pulse/fall_pulse outputs.
//
// state      | meaning
// S_LOW      | out_signal stable at 0, waiting for a high sample
// S_LOW_CHK  | qualifying a 0->1 change, counter holds the high samples seen
// S_HIGH     | out_signal stable at 1, waiting for a low sample
// S_HIGH_CHK | qualifying a 1->0 change, counter holds the low samples seen
module input_debounce_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  input  logic enable,
  output logic out_signal,
  output logic busy
`ifdef DEBOUNCE_EDGE_PULSE_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_LOW_CHK  = 2'b01,
    S_HIGH     = 2'b10,
    S_HIGH_CHK = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   out_nxt;
  logic                   busy_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LOW;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Disabling drops any candidate immediately, so re-enable always restarts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_LOW: begin
        if (enable && sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = S_HIGH;
          end else begin
            state_nxt = S_LOW_CHK;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      S_LOW_CHK: begin
        if (!enable || !sync_in) begin
          state_nxt = S_LOW;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (enable && !sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = S_LOW;
          end else begin
            state_nxt = S_HIGH_CHK;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      S_HIGH_CHK: begin
        if (!enable || sync_in) begin
          state_nxt = S_HIGH;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state flop.
  always_comb begin
    out_nxt  = (state_nxt == S_HIGH) || (state_nxt == S_HIGH_CHK);
    busy_nxt = (state_nxt == S_LOW_CHK) || (state_nxt == S_HIGH_CHK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_signal <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_signal <= out_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= out_nxt & ~out_signal;
      fall_pulse <= ~out_nxt & out_signal;
    end
  end
`endif

endmodule

// File: tb/tb_input_debounce_filter.sv
// Directed self-checking bench for input_debounce_filter at default parameters.
// Also covers rise_pulse/fall_pulse when DEBOUNCE_EDGE_PULSE_EN is defined.
module tb_input_debounce_filter;

  logic clk;
  logic reset_n;
  logic raw_in;
  logic enable;
  logic out_signal;
  logic busy;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_pulse;
  logic fall_pulse;
`endif

  int errors = 0;
  int checks = 0;

  input_debounce_filter #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .enable    (enable),
    .out_signal(out_signal),
    .busy      (busy)
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    raw_in  = 1'b1;
    enable  = 1'b1;
    #2;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (out_signal !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: out=%b busy=%b, want out=0 busy=0", e, out_signal, busy);
      end
    end
    raw_in  = 1'b0;
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (out_signal !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release edge %0d: out=%b busy=%b, want out=0 busy=0", e, out_signal, busy);
      end
    end
  endtask

  task automatic test_rise();
    logic exp_out, exp_busy;
    raw_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_busy = (e >= 3 && e <= 5);
      exp_out  = (e >= 6);
      checks++;
      if (out_signal !== exp_out || busy !== exp_busy) begin
        errors++;
        $display("FAIL rise edge %0d: out=%b busy=%b, want out=%b busy=%b",
                 e, out_signal, busy, exp_out, exp_busy);
      end
`ifdef DEBOUNCE_EDGE_PULSE_EN
      checks++;
      if (rise_pulse !== (e == 6) || fall_pulse !== 1'b0) begin
        errors++;
        $display("FAIL rise_pulse edge %0d: rise=%b fall=%b, want rise=%b fall=0",
                 e, rise_pulse, fall_pulse, (e == 6));
      end
`endif
    end
  endtask

  // Low for two samples, one high sample at edge 3, then low: fall lands at edge 9.
  task automatic test_fall_restart();
    logic exp_out, exp_busy;
    for (int e = 1; e <= 10; e++) begin
      raw_in = (e == 3);
      tick();
      exp_out  = (e < 9);
      exp_busy = (e == 3 || e == 4 || e == 6 || e == 7 || e == 8);
      checks++;
      if (out_signal !== exp_out || busy !== exp_busy) begin
        errors++;
        $display("FAIL fall_restart edge %0d: out=%b busy=%b, want out=%b busy=%b",
                 e, out_signal, busy, exp_out, exp_busy);
      end
`ifdef DEBOUNCE_EDGE_PULSE_EN
      checks++;
      if (fall_pulse !== (e == 9) || rise_pulse !== 1'b0) begin
        errors++;
        $display("FAIL fall_pulse edge %0d: fall=%b rise=%b, want fall=%b rise=0",
                 e, fall_pulse, rise_pulse, (e == 9));
      end
`endif
    end
  endtask

  task automatic test_glitch();
    logic exp_busy;
    for (int e = 1; e <= 10; e++) begin
      raw_in = (e <= 3);
      tick();
      exp_busy = (e >= 3 && e <= 5);
      checks++;
      if (out_signal !== 1'b0 || busy !== exp_busy) begin
        errors++;
        $display("FAIL glitch edge %0d: out=%b busy=%b, want out=0 busy=%b",
                 e, out_signal, busy, exp_busy);
      end
    end
  endtask

  task automatic test_enable();
    logic exp_out, exp_busy;
    raw_in = 1'b1;
    enable = 1'b1;
    for (int e = 1; e <= 3; e++) tick();
    checks++;
    if (busy !== 1'b1 || out_signal !== 1'b0) begin
      errors++;
      $display("FAIL enable_pre busy=%b out=%b, want busy=1 out=0", busy, out_signal);
    end
    enable = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || out_signal !== 1'b0) begin
        errors++;
        $display("FAIL enable_off edge %0d: busy=%b out=%b, want busy=0 out=0", e, busy, out_signal);
      end
    end
    enable = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      tick();
      exp_out  = (r >= 4);
      exp_busy = (r <= 3);
      checks++;
      if (out_signal !== exp_out || busy !== exp_busy) begin
        errors++;
        $display("FAIL enable_resume edge %0d: out=%b busy=%b, want out=%b busy=%b",
                 r, out_signal, busy, exp_out, exp_busy);
      end
    end
    enable = 1'b0;
    raw_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (out_signal !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold_high edge %0d: out=%b busy=%b, want out=1 busy=0", e, out_signal, busy);
      end
    end
    raw_in = 1'b1;
    for (int e = 1; e <= 3; e++) tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_fall_plain();
    logic exp_out, exp_busy;
    raw_in = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_out  = (e < 6);
      exp_busy = (e >= 3 && e <= 5);
      checks++;
      if (out_signal !== exp_out || busy !== exp_busy) begin
        errors++;
        $display("FAIL fall edge %0d: out=%b busy=%b, want out=%b busy=%b",
                 e, out_signal, busy, exp_out, exp_busy);
      end
    end
  endtask

  task automatic test_reset_midop();
    raw_in = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    checks++;
    if (out_signal !== 1'b1) begin
      errors++;
      $display("FAIL midop_pre out=%b, want 1", out_signal);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_signal !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_async out=%b busy=%b, want out=0 busy=0", out_signal, busy);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (out_signal !== 1'b0) begin
      errors++;
      $display("FAIL midop_release out=%b, want 0", out_signal);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall_restart();
    test_glitch();
    test_enable();
    test_fall_plain();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debounce_filter.md
Name: input_debounce_filter

Overview:
Upstream conditioning stage for the sequence-detector FSM. It synchronises an asynchronous raw input and debounces it, so only a level held stable for STABLE_CYCLES consecutive synchronised samples appears on out_signal. out_signal feeds the detector's in_signal directly, one clean level per clock.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on raw_in; legal range is 2 or more.
STABLE_CYCLES, 4, consecutive identical synchronised samples required to change out_signal; legal range is 1 or more.
CNT_W, $clog2(STABLE_CYCLES+1), localparam, width of the stability counter.

Ports:
clk        input   1  single clock; all state updates on rising edge
reset_n    input   1  asynchronous, active-low reset; deassertion is synchronised to clk externally
raw_in     input   1  asynchronous raw level (pin or comparator)
enable     input   1  filter enable; low freezes out_signal
out_signal output  1  debounced level, registered; connects to the detector's in_signal
busy       output  1  high while a candidate level change is being qualified

Behaviour:
- Reset (reset_n=0, takes effect immediately, no clk edge needed):
  - all synchroniser flops = 0
  - state = S_LOW, counter = 0
  - out_signal = 0, busy = 0
- Synchroniser:
  - SYNC_STAGES-flop chain, free-running, unaffected by enable
  - sync_in is the last stage
- FSM states: S_LOW, S_LOW_CHK, S_HIGH, S_HIGH_CHK.
- S_LOW:
  - sync_in=1 and STABLE_CYCLES=1: go to S_HIGH
  - sync_in=1 otherwise: go to S_LOW_CHK, counter=1
- S_LOW_CHK:
  - sync_in=0: glitch rejected; go to S_LOW, counter=0
  - sync_in=1 and counter==STABLE_CYCLES-1: go to S_HIGH, counter=0
  - sync_in=1 otherwise: counter+1
- S_HIGH and S_HIGH_CHK mirror S_LOW and S_LOW_CHK with polarity inverted.
- out_signal:
  - a flop, set/cleared on the same edge the FSM enters S_HIGH/S_LOW
  - equals 1 in S_HIGH and S_HIGH_CHK
  - never toggles while in a CHK state
- busy:
  - registered
  - 1 exactly while state is S_LOW_CHK or S_HIGH_CHK
- Latency:
  - a raw_in level first sampled at clk edge E, held steady, changes out_signal at edge E+SYNC_STAGES+STABLE_CYCLES-1
  - i.e. the (SYNC_STAGES+STABLE_CYCLES)-th edge counting E as 1
  - defaults: 6th edge
- Glitch boundary: a level held for fewer than STABLE_CYCLES synchronised samples never reaches out_signal.
- enable=0:
  - a CHK state returns to its stable state on the next edge, counter=0
  - S_LOW/S_HIGH hold regardless of sync_in
  - out_signal holds
- enable re-asserted: qualification restarts from count 0; no credit is kept for samples seen while disabled.
- Counter:
  - never exceeds STABLE_CYCLES-1
  - no wrap possible
  - width CNT_W is sufficient for all legal parameters
- Reset mid-qualification: abandons the candidate; out_signal=0 asynchronously, even if it was 1.
- Illegal state encodings (unreachable): recover to S_LOW on the next edge, out_signal=0.

Optional Feature:
DEBOUNCE_EDGE_PULSE_EN
- Defined:
  - adds outputs rise_pulse and fall_pulse, 1 bit each, registered, reset to 0
  - each is high for exactly one cycle, coincident with the first cycle out_signal shows the new level (rise: 0->1, fall: 1->0)
  - lets downstream logic count qualified edges without its own edge detector
- Undefined: the ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. Reset: hold reset_n=0, raw_in=1 for 5 clocks -> out_signal=0 and busy=0 throughout; release with raw_in=0 -> out_signal stays 0.
2. Rising level (defaults): raw_in 0->1 before edge 1, held -> busy=1 after edges 3-5, out_signal=1 after edge 6 and stays, busy=0 after edge 6.
3. Glitch: raw_in high for 3 clocks (< STABLE_CYCLES) then low -> out_signal stays 0; busy pulses then returns to 0; state back to S_LOW.
4. Falling level from out_signal=1: raw_in 1->0 held -> out_signal=0 after 6th edge. A 1-cycle return to 1 at sample 3 restarts the count, so the fall lands 6 edges after the last high sample.
5. Enable: enable=0 during S_LOW_CHK with raw_in held high -> busy=0 next edge, out_signal=0 held. Re-enable -> out_signal=1 exactly STABLE_CYCLES edges after enable returns high.
6. Reset mid-op: out_signal=1, assert reset_n=0 between edges -> out_signal=0 before next clk edge. With DEBOUNCE_EDGE_PULSE_EN, test 2 also shows rise_pulse=1 for exactly the 6th-edge cycle.
